// File: rtl/paint_dispenser.sv
// paint_dispenser: issues step pulses to the R/Y/B dispenser motors and counts them against per-colour targets.
// Define PAINT_DISPENSER_RAMP_EN to run the first RAMP_STEPS steps of each colour at half speed.
module paint_dispenser #(
   parameter int AMT_W      = 8,
   parameter int STEP_DIV   = 1000,
   parameter int RAMP_STEPS = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       motores,
   input  logic             trigger,
   input  logic [AMT_W-1:0] amount_r,
   input  logic [AMT_W-1:0] amount_y,
   input  logic [AMT_W-1:0] amount_b,
   output logic [2:0]       step,
   output logic [2:0]       flags,
   output logic             busy,
   output logic             err
);

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

`ifdef PAINT_DISPENSER_RAMP_EN
   localparam int DIV_W  = $clog2(2 * STEP_DIV);
   localparam int RAMP_W = $clog2(RAMP_STEPS + 2);
   localparam logic [DIV_W-1:0] DIV_SLOW = DIV_W'(2 * STEP_DIV - 1);
`else
   localparam int DIV_W  = $clog2(STEP_DIV);
`endif
   localparam logic [DIV_W-1:0] DIV_FAST = DIV_W'(STEP_DIV - 1);

   logic             state;
   logic             trig_q;
   logic             rise;
   logic             sel_valid;
   logic [1:0]       sel_idx;
   logic             multi_hot;
   logic [2:0]       run_cmd;
   logic [1:0]       run_idx;
   logic [AMT_W-1:0] rem [3];
   logic [DIV_W-1:0] div;
   logic [DIV_W-1:0] reload_start;
   logic [DIV_W-1:0] reload_next;
`ifdef PAINT_DISPENSER_RAMP_EN
   logic [RAMP_W-1:0] ramp_cnt [3];
`endif

   assign rise      = trigger & ~trig_q;
   assign multi_hot = (motores & (motores - 3'd1)) != 3'b000;
   assign busy      = (state == ST_RUN);

   // Multi-hot commands resolve to the highest-priority colour, R over Y over B.
   always_comb begin
      sel_valid = 1'b1;
      sel_idx   = 2'd0;
      if (motores[2])      sel_idx = 2'd2;
      else if (motores[1]) sel_idx = 2'd1;
      else if (motores[0]) sel_idx = 2'd0;
      else                 sel_valid = 1'b0;
   end

`ifdef PAINT_DISPENSER_RAMP_EN
   always_comb begin
      reload_start = (int'(ramp_cnt[sel_idx]) < RAMP_STEPS) ? DIV_SLOW : DIV_FAST;
      reload_next  = (int'(ramp_cnt[run_idx]) + 1 < RAMP_STEPS) ? DIV_SLOW : DIV_FAST;
   end
`else
   assign reload_start = DIV_FAST;
   assign reload_next  = DIV_FAST;
`endif

   // NOTE: every register here uses <= so all branches see the pre-edge values of rem, div and flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         trig_q  <= 1'b0;
         step    <= 3'b000;
         flags   <= 3'b000;
         err     <= 1'b0;
         div     <= '0;
         run_cmd <= 3'b000;
         run_idx <= 2'd0;
         // NOTE: the remaining-step array is tiny and drives the done logic, so it is reset like any flop.
         for (int i = 0; i < 3; i++) begin
            rem[i] <= '0;
`ifdef PAINT_DISPENSER_RAMP_EN
            ramp_cnt[i] <= '0;
`endif
         end
      end else begin
         trig_q <= trigger;
         err    <= multi_hot;
         step   <= 3'b000;
         if (rise) begin
            rem[2] <= amount_r;
            rem[1] <= amount_y;
            rem[0] <= amount_b;
            flags  <= 3'b000;
            state  <= ST_IDLE;
`ifdef PAINT_DISPENSER_RAMP_EN
            for (int i = 0; i < 3; i++) ramp_cnt[i] <= '0;
`endif
         end else if (state == ST_IDLE) begin
            if (sel_valid && !flags[sel_idx]) begin
               if (rem[sel_idx] != '0) begin
                  state   <= ST_RUN;
                  run_cmd <= motores;
                  run_idx <= sel_idx;
                  div     <= reload_start;
               end else begin
                  flags[sel_idx] <= 1'b1;
               end
            end
         end else begin
            // Any change of command pauses the colour; rem is kept and the divider restarts on resume.
            if (motores != run_cmd) begin
               state <= ST_IDLE;
            end else if (div != '0) begin
               div <= div - DIV_W'(1);
            end else begin
               step[run_idx] <= 1'b1;
               if (rem[run_idx] != '0) rem[run_idx] <= rem[run_idx] - AMT_W'(1);
               if (rem[run_idx] <= AMT_W'(1)) begin
                  flags[run_idx] <= 1'b1;
                  state          <= ST_IDLE;
               end else begin
                  div <= reload_next;
               end
`ifdef PAINT_DISPENSER_RAMP_EN
               if (int'(ramp_cnt[run_idx]) < RAMP_STEPS)
                  ramp_cnt[run_idx] <= ramp_cnt[run_idx] + RAMP_W'(1);
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_paint_dispenser.sv
// tb_paint_dispenser: scoreboard bench; expected step pulses are predicted from target amounts and step periods.
module tb_paint_dispenser;

   localparam int AMT_W      = 8;
   localparam int STEP_DIV   = 4;
   localparam int RAMP_STEPS = 4;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [2:0]       motores = 3'b000;
   logic             trigger = 1'b0;
   logic [AMT_W-1:0] amount_r = '0;
   logic [AMT_W-1:0] amount_y = '0;
   logic [AMT_W-1:0] amount_b = '0;
   logic [2:0]       step;
   logic [2:0]       flags;
   logic             busy;
   logic             err;

   paint_dispenser #(.AMT_W(AMT_W), .STEP_DIV(STEP_DIV), .RAMP_STEPS(RAMP_STEPS)) dut (
      .clk(clk), .reset(reset), .motores(motores), .trigger(trigger),
      .amount_r(amount_r), .amount_y(amount_y), .amount_b(amount_b),
      .step(step), .flags(flags), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [2:0] step;
      logic [2:0] flags;
   } ev_t;
   ev_t sb[$];

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: remaining steps, steps already taken, done flags.
   int         m_rem  [3];
   int         m_ramp [3];
   logic [2:0] m_flags;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic int period(input int ch);
`ifdef PAINT_DISPENSER_RAMP_EN
      return (m_ramp[ch] < RAMP_STEPS) ? 2 * STEP_DIV : STEP_DIV;
`else
      return STEP_DIV;
`endif
   endfunction

   // Monitor: every pulse must match the oldest prediction, on time and on the right colour.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         check("missed_step_cycle", cyc, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (step != 3'b000) begin
         if (sb.size() == 0) begin
            check("unexpected_step", int'(step), 0);
         end else begin
            ev_t e;
            e = sb.pop_front();
            check("step_cycle", cyc, e.cyc);
            check("step_bits", int'(step), int'(e.step));
            check("flags_at_step", int'(flags), int'(e.flags));
         end
      end
   end

   task automatic push_steps(input int ch, input int n, inout int prev);
      logic [2:0] bit_v;
      bit_v = 3'b001 << ch;
      for (int k = 0; k < n; k++) begin
         prev += period(ch);
         m_rem[ch]--;
         m_ramp[ch]++;
         if (m_rem[ch] == 0) m_flags |= bit_v;
         sb.push_back('{prev, bit_v, m_flags});
      end
   endtask

   task automatic batch(input int r, input int y, input int b);
      amount_r = AMT_W'(r);
      amount_y = AMT_W'(y);
      amount_b = AMT_W'(b);
      trigger  = 1'b1;
      motores  = 3'b000;
      tick(1);
      trigger  = 1'b0;
      amount_r = AMT_W'($urandom);
      amount_y = AMT_W'($urandom);
      amount_b = AMT_W'($urandom);
      m_rem[2] = r; m_rem[1] = y; m_rem[0] = b;
      for (int i = 0; i < 3; i++) m_ramp[i] = 0;
      m_flags = 3'b000;
      check("batch_flags_clear", int'(flags), 0);
   endtask

   task automatic dispense(input int ch, input logic [2:0] cmd, input int pause_after);
      int total, pushed, prev;
      total   = m_rem[ch];
      motores = cmd;
      prev    = cyc + 1;
      if (total == 0) begin
         m_flags |= (3'b001 << ch);
         tick(1);
         check("zero_amount_flags", int'(flags), int'(m_flags));
         check("zero_amount_busy", int'(busy), 0);
         return;
      end
      pushed = (pause_after > 0 && pause_after < total) ? pause_after : total;
      push_steps(ch, pushed, prev);
      tick(1);
      check("run_busy", int'(busy), 1);
      check("run_err", int'(err), int'($countones(cmd) > 1));
      if (pushed < total) begin
         tick(prev - cyc);
         motores = 3'b000;
         tick($urandom_range(2, 6));
         check("pause_busy", int'(busy), 0);
         motores = cmd;
         prev    = cyc + 1;
         push_steps(ch, total - pushed, prev);
      end
      tick(prev - cyc);
      check("done_flags", int'(flags), int'(m_flags));
      tick(1);
      check("done_busy", int'(busy), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   initial begin
      int prev, final_cyc;

      // Reset state
      reset = 1'b1;
      tick(2);
      check("reset_step", int'(step), 0);
      check("reset_flags", int'(flags), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_err", int'(err), 0);
      reset = 1'b0;
      tick(1);

      // Nominal full R -> Y -> B sequence
      batch(3, 2, 1);
      dispense(2, 3'b100, 0);
      dispense(1, 3'b010, 0);
      dispense(0, 3'b001, 0);
      check("sequence_flags_all", int'(flags), 7);

      // Pause after the first R pulse, zero Y amount
      batch(3, 0, 1);
      dispense(2, 3'b100, 1);
      dispense(1, 3'b010, 0);
      dispense(0, 3'b001, 0);

      // Multi-hot command: R wins and err is raised
      batch(2, 1, 1);
      dispense(2, 3'b110, 0);
      dispense(1, 3'b010, 0);
      check("err_cleared", int'(err), 0);
      dispense(0, 3'b001, 0);

      // Trigger rise coincides with the final B step
      batch(1, 0, 2);
      dispense(2, 3'b100, 0);
      dispense(1, 3'b010, 0);
      motores = 3'b001;
      prev = cyc + 1;
      push_steps(0, 1, prev);
      final_cyc = prev + period(0);
      tick(final_cyc - 1 - cyc);
      trigger  = 1'b1;
      amount_r = AMT_W'(3);
      amount_y = AMT_W'(1);
      amount_b = AMT_W'(2);
      tick(1);
      trigger = 1'b0;
      motores = 3'b000;
      check("rise_wins_flags", int'(flags), 0);
      check("rise_wins_step", int'(step), 0);
      m_rem[2] = 3; m_rem[1] = 1; m_rem[0] = 2;
      for (int i = 0; i < 3; i++) m_ramp[i] = 0;
      m_flags = 3'b000;
      tick(1);
      dispense(2, 3'b100, 0);
      dispense(1, 3'b010, 0);
      dispense(0, 3'b001, 0);

      // Randomized batches
      for (int n = 0; n < 10; n++) begin
         batch($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
         for (int ch = 2; ch >= 0; ch--) begin
            dispense(ch, 3'b001 << ch,
                     ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
         end
         check("random_flags_all", int'(flags), 7);
      end

      // Reset in the cycle a step would otherwise be issued
      batch(5, 0, 0);
      motores = 3'b100;
      tick(STEP_DIV);
      reset = 1'b1;
      tick(1);
      check("midrun_reset_step", int'(step), 0);
      check("midrun_reset_busy", int'(busy), 0);
      check("midrun_reset_flags", int'(flags), 0);
      reset   = 1'b0;
      motores = 3'b000;
      tick(3 * STEP_DIV);

      check("scoreboard_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
